// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell walks a WIDTH-bit operand
// pair LSB-first, one bit per clock, behind a start/busy/done handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; last result held on sum/cout/ovf
//   RUN   | shifting one bit pair per clock through the full adder
//   DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    // Bit index whose carry-out is the carry into the MSB, and the MSB itself.
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_pre_q, ovf_pre_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_c;

    // The single full-adder cell, fed from the low bits of the shift registers.
    assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    // Next-state and datapath update; everything holds unless a branch changes it.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        ovf_pre_d = ovf_pre_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and force carry-in.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_PRE) begin
                    ovf_pre_d = fa_c;
                end
                if (cnt_q == CNT_LAST) begin
                    // Signed overflow: carry into MSB differs from carry out of it.
                    cout_d  = fa_c;
                    ovf_d   = ovf_pre_q ^ fa_c;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            ovf_pre_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            ovf_pre_q <= ovf_pre_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, handshake corner
// cases and random ops on an 8-bit instance, exhaustive sweep on a 4-bit one.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic [7:0] sum8;
    logic       cout8, ovf8, busy8, done8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic [3:0] sum4;
    logic       cout4, ovf4, busy4, done4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .sub  (sub8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (sum8),
        .cout (cout8),
        .ovf  (ovf8),
        .busy (busy8),
        .done (done8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .start(start4),
        .sub  (sub4),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .sum  (sum4),
        .cout (cout4),
        .ovf  (ovf4),
        .busy (busy4),
        .done (done4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: plain integer sums, signed range test for overflow.
    task automatic ref_model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                             input logic ic, input logic is,
                             output logic [31:0] es, output logic ec, output logic eo);
        logic [63:0] m, bb, full;
        longint      sa, sb, r, lim;
        m    = (64'd1 << w) - 64'd1;
        bb   = is ? (~{32'd0, ib}) & m : {32'd0, ib};
        full = {32'd0, ia} + bb + (is ? 64'd1 : {63'd0, ic});
        es   = full[31:0] & m[31:0];
        ec   = full[w];
        sa   = longint'({32'd0, ia});
        sb   = longint'({32'd0, ib});
        if (ia[w-1]) sa = sa - (longint'(1) << w);
        if (ib[w-1]) sb = sb - (longint'(1) << w);
        r    = is ? (sa - sb) : (sa + sb + (ic ? longint'(1) : longint'(0)));
        lim  = longint'(1) << (w - 1);
        eo   = (r >= lim) || (r < -lim);
    endtask

    task automatic run_op8(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic, input string tag);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        ref_model(8, {24'd0, ia}, {24'd0, ib}, ic, s, es, ec, eo);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = ia; b8 = ib; cin8 = ic;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        chk({tag, " busy"}, 32'(busy8), 32'd1);
        chk({tag, " sum_clr"}, 32'(sum8), 32'd0);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd8);
        chk({tag, " result"}, 32'({ovf8, cout8, sum8}), 32'({eo, ec, es[7:0]}));
        chk({tag, " busy_low"}, 32'(busy8), 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done8), 32'd0);
        chk({tag, " hold"}, 32'({ovf8, cout8, sum8}), 32'({eo, ec, es[7:0]}));
    endtask

    task automatic run_op4(input logic s, input logic [3:0] ia, input logic [3:0] ib,
                           input logic ic);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        string       tag;
        ref_model(4, {28'd0, ia}, {28'd0, ib}, ic, s, es, ec, eo);
        tag = $sformatf("w4 sub=%0d cin=%0d a=%h b=%h", s, ic, ia, ib);
        @(negedge clk);
        start4 = 1'b1; sub4 = s; a4 = ia; b4 = ib; cin4 = ic;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " result"}, 32'({ovf4, cout4, sum4}), 32'({eo, ec, es[3:0]}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ndone, first_done, c;
        logic [31:0] es;
        logic        ec, eo;

        rst = 1'b1;
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        start4 = 1'b1; sub4 = 1'b0; a4 = 4'h1; b4 = 4'h2; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst w8 outputs", 32'({sum8, cout8, ovf8, busy8, done8}), 32'd0);
        chk("rst w4 outputs", 32'({sum4, cout4, ovf4, busy4, done4}), 32'd0);
        start8 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle after rst", 32'({busy8, done8, busy4, done4}), 32'd0);

        run_op8(1'b0, 8'hFF, 8'h01, 1'b0, "add ff+01");
        run_op8(1'b0, 8'h7F, 8'h01, 1'b0, "add 7f+01");
        run_op8(1'b1, 8'h05, 8'h07, 1'b0, "sub 05-07");
        run_op8(1'b1, 8'h80, 8'h01, 1'b0, "sub 80-01");
        run_op8(1'b1, 8'h05, 8'h07, 1'b1, "sub cin ignored");
        run_op8(1'b0, 8'h80, 8'h80, 1'b1, "add 80+80+1");

        // A second start mid-RUN must not disturb the op in flight.
        ref_model(8, 32'h3C, 32'h5A, 1'b1, 1'b0, es, ec, eo);
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1;
        ndone = 0; first_done = -1;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = cyc;
                    chk("ignore result", 32'({ovf8, cout8, sum8}), 32'({eo, ec, es[7:0]}));
                end
            end
            start8 = (cyc == 2);
            if (cyc == 2) begin
                sub8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F; cin8 = 1'b0;
            end
        end
        chk("ignore done count", 32'(ndone), 32'd1);
        chk("ignore latency", 32'(first_done), 32'd8);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        @(negedge clk);
        sub8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        c = 0;
        while (!done8 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("b2b first latency", 32'(c), 32'd8);
        chk("b2b first result", 32'({ovf8, cout8, sum8}), 32'h0_0_47);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                start8 = 1'b0;
                chk("b2b rerun", 32'({busy8, done8}), 32'b10);
            end
        end while (!done8 && c < 40);
        ref_model(8, 32'h10, 32'h20, 1'b0, 1'b1, es, ec, eo);
        chk("b2b spacing", 32'(c), 32'd9);
        chk("b2b second result", 32'({ovf8, cout8, sum8}), 32'({eo, ec, es[7:0]}));

        // Reset during RUN aborts the op.
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("partial sum", 32'(sum8), 32'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort outputs", 32'({sum8, cout8, ovf8, busy8, done8}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort no done", 32'(ndone), 32'd0);
        run_op8(1'b0, 8'hA5, 8'h5B, 1'b1, "after abort");

        for (int i = 0; i < 120; i++) begin
            run_op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    $sformatf("rand%0d", i));
        end

        for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
                for (int ia = 0; ia < 16; ia++)
                    for (int ib = 0; ib < 16; ib++)
                        run_op4(1'(s), 4'(ia), 4'(ib), 1'(ci));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: a single full-adder cell processes a WIDTH-bit operand pair LSB-first, one bit per clock.
- Uses a start/busy/done handshake, with a registered result and carry, overflow and borrow flags.
- Serves as the area-minimal arithmetic unit in the datapath, in place of a WIDTH-bit ripple adder built from full_adder instances.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk    input   1      system clock, rising edge.
- rst    input   1      synchronous reset, active-high.
- start  input   1      request operation; sampled only when busy=0.
- sub    input   1      0: a+b+cin; 1: a-b (cin ignored); sampled with start.
- a      input   WIDTH  operand A; sampled with start.
- b      input   WIDTH  operand B; sampled with start.
- cin    input   1      carry-in for add mode; sampled with start.
- sum    output  WIDTH  result; holds its value until the next accepted start.
- cout   output  1      carry out of MSB; in sub mode, 1 = no borrow.
- ovf    output  1      two's-complement signed overflow.
- busy   output  1      1 while in RUN.
- done   output  1      one-cycle pulse when sum/cout/ovf become valid.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; bit counter=0; carry reg=0.
  - Reset overrides every other input.
  - Reset mid-RUN aborts the operation: no done pulse, and the partial sum is cleared to 0.
- States: IDLE, RUN, DONE.
- Operand acceptance (IDLE or DONE with start=1):
  - Load shift reg A<=a.
  - Load shift reg B<=b if sub=0, else ~b.
  - carry<=cin if sub=0, else 1.
  - counter<=0; clear sum/cout/ovf to 0; go to RUN (busy=1 from the next cycle).
- RUN, each edge:
  - s = A[0]^B[0]^carry; c = A[0]&B[0] | carry&(A[0]^B[0]).
  - sum shifts right with s entering at bit WIDTH-1.
  - A and B shift right; carry<=c; counter<=counter+1.
  - On the edge where counter==WIDTH-2, latch ovf_pre = c (the carry into the MSB).
  - On the edge where counter==WIDTH-1 (MSB processed):
    - cout<=c; ovf<=ovf_pre^c.
    - go to DONE: done=1, busy=0.
- DONE:
  - Lasts exactly one cycle, then IDLE unless start=1.
  - start=1 in DONE is accepted, giving back-to-back operation.
  - done then drops and busy rises the next cycle.
- start while busy=1 is ignored; the operands in flight are unaffected.
- Latency and throughput:
  - start accepted at edge k -> busy=1 for edges k+1..k+WIDTH.
  - done=1 in the cycle following edge k+WIDTH; sum is valid in that same cycle.
  - Throughput is one op per WIDTH+1 cycles.
- Arithmetic: {cout,sum} == a + b + cin (add mode), or a + ~b + 1 (sub mode), modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH); no wrap-around occurs before the DONE transition.
- sum, cout and ovf are stable (no glitches) from the done pulse until the next accepted start.

Test Plan:
- WIDTH=8, add: a=8'hFF, b=8'h01, cin=0 -> done exactly 8 cycles after the start edge; sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- WIDTH=8, sub: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1. Check that cin=1 is ignored in sub mode.
- Start is pulsed again at cycle 3 of RUN with different operands -> ignored: original result delivered, exactly one done pulse.
- Back-to-back: start held high through DONE -> the second op is accepted in the DONE cycle; the second done follows 9 cycles after the first.
- rst asserted at RUN cycle 4 -> next cycle sum=0, busy=0, done=0; no done pulse appears afterwards; a fresh op then completes correctly.
- WIDTH=4, exhaustive: all a, b, cin, sub combinations (1024 ops) checked against a behavioural reference of {cout,sum} and signed overflow; mismatches are reported with the failing input combination.
